// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_STREAMS AXI-Stream inputs onto one output.
// A grant is held for a whole packet (through tlast); data paths are purely combinational.
//
// state  | meaning
// S_IDLE | no grant; scan requesters from ptr when c_enable=1
// S_PASS | stream g owns the output until its tlast beat transfers
module axis_packet_arbiter #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2
) (
    input  logic                                   clk,
    input  logic                                   areset,
    input  logic                                   c_enable,
    output logic                                   c_busy,
    output logic [NUM_STREAMS-1:0]                 c_grant,
    input  logic [NUM_STREAMS-1:0]                 axis_i_tvalid,
    output logic [NUM_STREAMS-1:0]                 axis_i_tready,
    input  logic [NUM_STREAMS-1:0]                 axis_i_tlast,
    input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]    axis_i_tdata,
    input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0]  axis_i_tuser,
    output logic                                   axis_o_tvalid,
    input  logic                                   axis_o_tready,
    output logic                                   axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]                axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]              axis_o_tuser
);

    localparam int DW    = AXIS_BYTES * 8;
    localparam int UW    = AXIS_USER_BITS;
    localparam int IDX_W = $clog2(NUM_STREAMS);

    typedef enum logic {
        S_IDLE,
        S_PASS
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   g;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand;
    logic               arb_found;
    logic               sel_valid;
    logic               pkt_end;

    // First requester at or after ptr, wrapping past the top index.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr;
        cand      = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_STREAMS);
            if (!arb_found && axis_i_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        axis_o_tdata  = '0;
        axis_o_tuser  = '0;
        axis_o_tlast  = 1'b0;
        sel_valid     = 1'b0;
        axis_i_tready = '0;
        for (int k = 0; k < NUM_STREAMS; k++) begin
            if (IDX_W'(k) == g) begin
                axis_o_tdata     = axis_i_tdata[k*DW +: DW];
                axis_o_tuser     = axis_i_tuser[k*UW +: UW];
                axis_o_tlast     = axis_i_tlast[k];
                sel_valid        = axis_i_tvalid[k];
                axis_i_tready[k] = c_busy & axis_o_tready;
            end
        end
    end

    assign axis_o_tvalid = c_busy & sel_valid;
    assign pkt_end       = axis_o_tvalid & axis_o_tready & axis_o_tlast;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            g       <= '0;
            c_busy  <= 1'b0;
            c_grant <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (c_enable && arb_found) begin
                        state   <= S_PASS;
                        g       <= arb_idx;
                        c_busy  <= 1'b1;
                        c_grant <= NUM_STREAMS'(1) << arb_idx;
                    end
                end
                S_PASS: begin
                    // c_enable is deliberately ignored here so a packet is never cut short.
                    if (pkt_end) begin
                        state   <= S_IDLE;
                        ptr     <= (int'(g) == NUM_STREAMS - 1) ? '0 : g + 1'b1;
                        c_busy  <= 1'b0;
                        c_grant <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    c_busy  <= 1'b0;
                    c_grant <= '0;
                end
            endcase
        end
    end

endmodule
